reset_sequencer: RTL and testbench
==================================

Name: reset_sequencer

Overview:
Parametrised core bring-up controller. Releases the core only after a defined init sequence:
- clears every register-file entry;
- clears a configurable window of data memory, honouring memory backpressure;
- loads the reset PC with a one-cycle pulse;
- asserts run_o.

Sits between the top-level reset and the core datapath. Supports software-requested re-initialisation.

Parameters:
XLEN, 32, data/address width
RF_DEPTH, 32, register-file entries cleared (>=2)
MEM_DEPTH, 1024, data-memory words cleared (>=1)
RESET_PC, 32'h8000_0000, PC value loaded at end of sequence
CLEAR_VAL, '0, value written to every cleared location

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
soft_rst_i  in  1  re-init request, sampled only in RUN
mem_ready_i  in  1  data memory accepts a write this cycle
rf_we_o  out  1  register-file write enable
rf_addr_o  out  $clog2(RF_DEPTH)  register-file index
rf_data_o  out  XLEN  register-file write data (CLEAR_VAL)
mem_we_o  out  1  data-memory write request
mem_addr_o  out  XLEN  byte address = word_index*(XLEN/8)
mem_data_o  out  XLEN  memory write data (CLEAR_VAL)
pc_load_o  out  1  one-cycle PC load strobe
pc_init_o  out  XLEN  RESET_PC, valid while pc_load_o=1
busy_o  out  1  sequence in progress
run_o  out  1  core may execute

Behaviour:
- Interface timing: one clock, clk_i. Reset rst_i is synchronous and active-high, and dominates every state.
- Output type: all outputs are Moore decodes of the registered state and counters. No combinational path from inputs to outputs, except mem_ready_i gating the counter.
- States: RESET, CLR_RF, CLR_MEM, LOAD_PC, RUN.
- RESET (held while rst_i=1):
  - all outputs 0, except rf_data_o/mem_data_o = CLEAR_VAL and pc_init_o = RESET_PC;
  - counters cleared.
  - First edge with rst_i=0 -> CLR_RF.
- CLR_RF:
  - rf_we_o=1 and busy_o=1; rf_addr_o = rf counter, starting at 0;
  - counter increments every cycle;
  - x0 is included.
  - Edge with counter=RF_DEPTH-1 -> CLR_MEM, counter cleared.
- CLR_MEM:
  - mem_we_o=1 and busy_o=1; mem_addr_o = mem counter*(XLEN/8);
  - counter advances only on edges where mem_ready_i=1;
  - with mem_ready_i=0, address/data are held stable and mem_we_o stays 1.
  - Accepted write at counter=MEM_DEPTH-1 -> LOAD_PC.
- LOAD_PC: pc_load_o=1 and busy_o=1 for exactly one cycle -> RUN.
- RUN:
  - run_o=1, busy_o=0, all write enables 0.
  - soft_rst_i=1 -> CLR_RF (counters cleared), run_o drops on that edge.
- soft_rst_i is ignored outside RUN.
- Latency: with mem_ready_i held 1, run_o first rises on edge RF_DEPTH+MEM_DEPTH+2 after the first edge with rst_i low. Each mem_ready_i=0 cycle in CLR_MEM adds 1.
- Mid-sequence reset: rst_i=1 in any state -> RESET on that edge, and the sequence restarts from index 0 afterwards. No partial-resume.
- Simultaneous events: rst_i and soft_rst_i together -> rst_i wins.
- Counter widths: sized to $clog2(depth)+1 so the terminal compare never wraps; mem_addr_o is zero-extended to XLEN.

Optional Feature:
Macro: RESET_SEQ_MEM_CLEAR_EN
- Defined: behaviour as above.
- Undefined:
  - CLR_MEM does not exist; CLR_RF goes directly to LOAD_PC;
  - mem_we_o is tied 0 and mem_addr_o is tied 0;
  - mem_ready_i is unused;
  - latency becomes RF_DEPTH+2.

Decomposition:
- nyakuo_pkg:
  - seq_state_e enum (logic [2:0]: RESET, CLR_RF, CLR_MEM, LOAD_PC, RUN);
  - XLEN constant;
  - DEFAULT_RESET_PC = 32'h8000_0000.
- Sub-module seq_counter:
  - parametrised WIDTH/LAST;
  - inputs clk_i, rst_i, clr_i, en_i;
  - outputs cnt_o, last_o;
  - instantiated once for rf, once for mem.

Test Plan:
1. RF_DEPTH=4, MEM_DEPTH=8, mem_ready_i=1, release rst_i:
   - rf_we_o high 4 cycles, addr 0,1,2,3;
   - mem_we_o high 8 cycles, mem_addr_o 0x0..0x1C step 4;
   - pc_load_o single pulse with pc_init_o=0x8000_0000;
   - run_o high on edge 14.
2. Same params, mem_ready_i low on accepts 2 and 5 (3 stall cycles each):
   - mem_addr_o holds 0x8 and 0x14 during stalls;
   - run_o on edge 20;
   - no address skipped or repeated.
3. rst_i asserted mid-CLR_MEM (addr 0x10), released 2 cycles later:
   - outputs zero during reset;
   - sequence restarts at rf_addr_o=0;
   - full latency 14 again.
4. In RUN, 1-cycle soft_rst_i pulse:
   - run_o drops next edge;
   - CLR_RF from 0;
   - run_o returns 14 edges later.
5. soft_rst_i held 1 throughout CLR_RF/CLR_MEM: no effect on the sequence.
6. Build without RESET_SEQ_MEM_CLEAR_EN, RF_DEPTH=4:
   - mem_we_o never 1;
   - run_o on edge 6.

Source files
------------

// File: rtl/nyakuo_pkg.sv
// Shared types and constants for the core bring-up sequencer.
package nyakuo_pkg;

    localparam int XLEN = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

    typedef enum logic [2:0] {
        RESET   = 3'd0,
        CLR_RF  = 3'd1,
        CLR_MEM = 3'd2,
        LOAD_PC = 3'd3,
        RUN     = 3'd4
    } seq_state_e;

endpackage

// File: rtl/reset_sequencer_if.sv
// Bring-up bus between the reset sequencer and the core/memory side.
// The master modport is the sequencer; the slave modport is the core side.
interface reset_sequencer_if #(
    parameter int XLEN  = nyakuo_pkg::XLEN,
    parameter int RF_AW = 5
);
    logic             soft_rst_i;
    logic             mem_ready_i;
    logic             rf_we_o;
    logic [RF_AW-1:0] rf_addr_o;
    logic [XLEN-1:0]  rf_data_o;
    logic             mem_we_o;
    logic [XLEN-1:0]  mem_addr_o;
    logic [XLEN-1:0]  mem_data_o;
    logic             pc_load_o;
    logic [XLEN-1:0]  pc_init_o;
    logic             busy_o;
    logic             run_o;

    modport master (
        input  soft_rst_i, mem_ready_i,
        output rf_we_o, rf_addr_o, rf_data_o,
        output mem_we_o, mem_addr_o, mem_data_o,
        output pc_load_o, pc_init_o, busy_o, run_o
    );

    modport slave (
        output soft_rst_i, mem_ready_i,
        input  rf_we_o, rf_addr_o, rf_data_o,
        input  mem_we_o, mem_addr_o, mem_data_o,
        input  pc_load_o, pc_init_o, busy_o, run_o
    );
endinterface

// File: rtl/seq_counter.sv
// Clearable up-counter with a terminal-value flag, used to walk the
// register file and the data-memory window during bring-up.
module seq_counter #(
    parameter int WIDTH = 4,
    parameter int LAST  = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             last_o
);
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Clear has priority over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q == WIDTH'(LAST));
endmodule

// File: rtl/reset_sequencer.sv
// Core bring-up controller: clears the register file, optionally clears a
// data-memory window (macro RESET_SEQ_MEM_CLEAR_EN), pulses the PC load and
// then lets the core run. All outputs are decoded from registered state.
module reset_sequencer #(
    parameter int              XLEN      = nyakuo_pkg::XLEN,
    parameter int              RF_DEPTH  = 32,
    parameter int              MEM_DEPTH = 1024,
    parameter logic [XLEN-1:0] RESET_PC  = XLEN'(nyakuo_pkg::DEFAULT_RESET_PC),
    parameter logic [XLEN-1:0] CLEAR_VAL = '0
) (
    input logic               clk_i,
    input logic               rst_i,
    reset_sequencer_if.master bus
);
    import nyakuo_pkg::*;

    localparam int RF_AW = $clog2(RF_DEPTH);
    // One spare bit so the terminal compare never wraps.
    localparam int RF_CW = RF_AW + 1;

`ifdef RESET_SEQ_MEM_CLEAR_EN
    localparam seq_state_e AFTER_RF = CLR_MEM;
    localparam int MEM_CW = $clog2(MEM_DEPTH) + 1;
`else
    localparam seq_state_e AFTER_RF = LOAD_PC;
`endif

    seq_state_e state_q;
    seq_state_e state_d;

    logic [RF_CW-1:0] rf_cnt;
    logic             rf_last;
    logic             rf_cnt_msb_unused;

    // Register-file index: held at 0 outside CLR_RF, cleared on the last entry.
    seq_counter #(
        .WIDTH (RF_CW),
        .LAST  (RF_DEPTH - 1)
    ) u_rf_cnt (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  ((state_q != CLR_RF) || rf_last),
        .en_i   (1'b1),
        .cnt_o  (rf_cnt),
        .last_o (rf_last)
    );

    assign rf_cnt_msb_unused = rf_cnt[RF_AW];

`ifdef RESET_SEQ_MEM_CLEAR_EN
    logic [MEM_CW-1:0] mem_cnt;
    logic              mem_last;
    logic              mem_accept;

    assign mem_accept = (state_q == CLR_MEM) && bus.mem_ready_i;

    // Memory word index: advances only on accepted writes.
    seq_counter #(
        .WIDTH (MEM_CW),
        .LAST  (MEM_DEPTH - 1)
    ) u_mem_cnt (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  ((state_q != CLR_MEM) || (mem_accept && mem_last)),
        .en_i   (mem_accept),
        .cnt_o  (mem_cnt),
        .last_o (mem_last)
    );
`else
    logic mem_ready_unused;
    assign mem_ready_unused = bus.mem_ready_i;
`endif

    // State register; reset dominates every state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and Moore output decode.
    always_comb begin
        state_d        = state_q;
        bus.rf_we_o    = 1'b0;
        bus.mem_we_o   = 1'b0;
        bus.mem_addr_o = '0;
        bus.pc_load_o  = 1'b0;
        bus.busy_o     = 1'b0;
        bus.run_o      = 1'b0;
        case (state_q)
            RESET: begin
                state_d = CLR_RF;
            end
            CLR_RF: begin
                bus.rf_we_o = 1'b1;
                bus.busy_o  = 1'b1;
                if (rf_last) begin
                    state_d = AFTER_RF;
                end
            end
`ifdef RESET_SEQ_MEM_CLEAR_EN
            CLR_MEM: begin
                bus.mem_we_o   = 1'b1;
                bus.busy_o     = 1'b1;
                bus.mem_addr_o = XLEN'(mem_cnt) * XLEN'(XLEN / 8);
                if (mem_accept && mem_last) begin
                    state_d = LOAD_PC;
                end
            end
`endif
            LOAD_PC: begin
                bus.pc_load_o = 1'b1;
                bus.busy_o    = 1'b1;
                state_d       = RUN;
            end
            RUN: begin
                bus.run_o = 1'b1;
                if (bus.soft_rst_i) begin
                    state_d = CLR_RF;
                end
            end
            default: begin
                state_d = RESET;
            end
        endcase
    end

    assign bus.rf_addr_o  = rf_cnt[RF_AW-1:0];
    assign bus.rf_data_o  = CLEAR_VAL;
    assign bus.mem_data_o = CLEAR_VAL;
    assign bus.pc_init_o  = RESET_PC;
endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with RF_DEPTH=4, MEM_DEPTH=8.
// Expected latencies depend on whether RESET_SEQ_MEM_CLEAR_EN is defined.
module tb_reset_sequencer;
    localparam int RF_DEPTH  = 4;
    localparam int MEM_DEPTH = 8;

`ifdef RESET_SEQ_MEM_CLEAR_EN
    localparam bit MEM_EN    = 1'b1;
    localparam int LAT_PLAIN = 14;
`else
    localparam bit MEM_EN    = 1'b0;
    localparam int LAT_PLAIN = 6;
`endif

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    reset_sequencer_if #(.XLEN(32), .RF_AW(2)) bus_if ();

    reset_sequencer #(
        .XLEN      (32),
        .RF_DEPTH  (RF_DEPTH),
        .MEM_DEPTH (MEM_DEPTH),
        .RESET_PC  (32'h8000_0000),
        .CLEAR_VAL (32'h0)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus_if)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rf_we"},    bus_if.rf_we_o,    0);
        chk({tag, "_rf_addr"},  bus_if.rf_addr_o,  0);
        chk({tag, "_rf_data"},  bus_if.rf_data_o,  0);
        chk({tag, "_mem_we"},   bus_if.mem_we_o,   0);
        chk({tag, "_mem_addr"}, bus_if.mem_addr_o, 0);
        chk({tag, "_mem_data"}, bus_if.mem_data_o, 0);
        chk({tag, "_pc_load"},  bus_if.pc_load_o,  0);
        chk({tag, "_pc_init"},  bus_if.pc_init_o,  64'h8000_0000);
        chk({tag, "_busy"},     bus_if.busy_o,     0);
        chk({tag, "_run"},      bus_if.run_o,      0);
        $display("[%0t] %s: reset outputs checked", $time, tag);
    endtask

    // Walks one full bring-up cycle by cycle. Started either by releasing
    // rst_i or by a one-cycle soft reset from RUN. Memory word indices sa/sb
    // each see ns stall cycles before being accepted.
    task automatic walk(input string tag, input bit via_soft, input bit hold_soft,
                        input int sa, input int sb, input int ns);
        bus_if.mem_ready_i = 1'b1;
        if (via_soft) bus_if.soft_rst_i = 1'b1;
        else          rst_i = 1'b0;
        if (hold_soft) bus_if.soft_rst_i = 1'b1;
        tick();
        bus_if.soft_rst_i = hold_soft;
        for (int r = 0; r < RF_DEPTH; r++) begin
            chk({tag, "_rf_we"},   bus_if.rf_we_o,   1);
            chk({tag, "_rf_addr"}, bus_if.rf_addr_o, r);
            chk({tag, "_rf_busy"}, bus_if.busy_o,    1);
            chk({tag, "_rf_run"},  bus_if.run_o,     0);
            chk({tag, "_rf_mwe"},  bus_if.mem_we_o,  0);
            tick();
        end
        if (MEM_EN) begin
            for (int m = 0; m < MEM_DEPTH; m++) begin
                int st;
                st = (m == sa || m == sb) ? ns : 0;
                for (int s = 0; s <= st; s++) begin
                    bus_if.mem_ready_i = (s == st);
                    chk({tag, "_mem_we"},   bus_if.mem_we_o,   1);
                    chk({tag, "_mem_addr"}, bus_if.mem_addr_o, m * 4);
                    chk({tag, "_mem_busy"}, bus_if.busy_o,     1);
                    chk({tag, "_mem_rfwe"}, bus_if.rf_we_o,    0);
                    chk({tag, "_mem_run"},  bus_if.run_o,      0);
                    tick();
                end
            end
        end
        bus_if.mem_ready_i = 1'b1;
        bus_if.soft_rst_i  = 1'b0;
        chk({tag, "_pc_load"}, bus_if.pc_load_o, 1);
        chk({tag, "_pc_init"}, bus_if.pc_init_o, 64'h8000_0000);
        chk({tag, "_pc_busy"}, bus_if.busy_o,    1);
        chk({tag, "_pc_run"},  bus_if.run_o,     0);
        chk({tag, "_pc_mwe"},  bus_if.mem_we_o,  0);
        tick();
        chk({tag, "_run"},      bus_if.run_o,     1);
        chk({tag, "_run_busy"}, bus_if.busy_o,    0);
        chk({tag, "_run_pcl"},  bus_if.pc_load_o, 0);
        chk({tag, "_run_rfwe"}, bus_if.rf_we_o,   0);
        chk({tag, "_run_mwe"},  bus_if.mem_we_o,  0);
        tick();
        chk({tag, "_run_hold"}, bus_if.run_o,     1);
        $display("[%0t] %s: sequence walked to RUN", $time, tag);
    endtask

    // Counts edges from a soft-reset pulse until run_o rises again.
    task automatic measure_soft(input string tag, input int exp);
        int  n;
        bit  seen;
        n    = 0;
        seen = 1'b0;
        bus_if.soft_rst_i = 1'b1;
        tick();
        n++;
        bus_if.soft_rst_i = 1'b0;
        chk({tag, "_drop"}, bus_if.run_o, 0);
        while (n < 100) begin
            if (bus_if.run_o) begin
                seen = 1'b1;
                break;
            end
            tick();
            n++;
        end
        chk({tag, "_seen"},    seen, 1);
        chk({tag, "_latency"}, n,    exp);
        $display("[%0t] %s: run_o back after %0d edges", $time, tag, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        bus_if.soft_rst_i  = 1'b0;
        bus_if.mem_ready_i = 1'b1;
        rst_i = 1'b1;
        repeat (3) tick();
        check_reset_outputs("por");

        // Plain bring-up.
        walk("t1", 1'b0, 1'b0, -1, -1, 0);

        // Bring-up with two stalled memory writes (words 2 and 5).
        rst_i = 1'b1;
        tick();
        check_reset_outputs("t2_rst");
        walk("t2", 1'b0, 1'b0, 2, 5, 3);

        // Reset in the middle of the sequence, held for two edges.
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (MEM_EN ? (bus_if.mem_we_o && bus_if.mem_addr_o == 32'h10)
                       : (bus_if.rf_we_o && bus_if.rf_addr_o == 2'd2)) begin
                found = 1'b1;
                break;
            end
        end
        chk("t3_reach_mid", found, 1);
        rst_i = 1'b1;
        tick();
        check_reset_outputs("t3_rst_a");
        tick();
        check_reset_outputs("t3_rst_b");
        walk("t3", 1'b0, 1'b0, -1, -1, 0);

        // Soft re-init from RUN, then a latency measurement.
        walk("t4", 1'b1, 1'b0, -1, -1, 0);
        measure_soft("t4m", LAT_PLAIN);

        // soft_rst_i held high through the clearing phases.
        rst_i = 1'b1;
        tick();
        walk("t5", 1'b0, 1'b1, -1, -1, 0);

        // rst_i and soft_rst_i together in RUN: reset wins.
        rst_i = 1'b1;
        bus_if.soft_rst_i = 1'b1;
        tick();
        check_reset_outputs("t7_both");
        bus_if.soft_rst_i = 1'b0;
        tick();
        check_reset_outputs("t7_held");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
